// File: rtl/instrn_mem_loader_pkg.sv
// Shared types and sizes for the instruction-memory loader.
// The helper saturates the loaded-word counter at its maximum.
package instrn_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE,
        ERR
    } state_e;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [7:0] COUNT_MAX = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == COUNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/instrn_mem_loader_if.sv
// Instruction word stream: valid/ready with a last-word marker.
// Source (master) holds word_in/word_last until it sees word_ready.
interface instrn_mem_loader_if;
    import instrn_mem_loader_pkg::*;

    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_last;
    logic              word_ready;

    modport master (output word_in, word_valid, word_last, input word_ready);
    modport slave  (input word_in, word_valid, word_last, output word_ready);
endinterface

// File: rtl/instrn_mem_loader.sv
// Splits each accepted 32-bit word into 4 little-endian byte writes; holds the CPU during a load.
// Handshake in cycle N -> mem_we in N+1..N+4, word_ready/done in N+5; word_ready low while writing.
module instrn_mem_loader
    import instrn_mem_loader_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instrn_mem_loader_if.slave  word_if,
    output logic                mem_we,
    output logic [31:0]         mem_addr,
    output logic [BYTE_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic                cpu_hold,
    output logic [7:0]          word_count
);

    localparam logic [31:0] BASE  = 32'(BASE_ADDR);
    localparam logic [31:0] LIMIT = 32'(BASE_ADDR + MEM_BYTES);
    localparam logic [31:0] STEP  = 32'(BYTES_PER_WORD);

    state_e             state_q;
    logic [31:0]        addr_q;
    logic [WORD_W-1:0]  word_q;
    logic               last_q;
    logic [1:0]         byte_idx_q;
    logic               word_ready_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [BYTE_W-1:0]  mem_wdata_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               cpu_hold_q;
    logic [7:0]         word_count_q;

    logic [1:0]         byte_idx_d;
    logic [31:0]        addr_d;
    logic               overflow;

    assign byte_idx_d = byte_idx_q + 2'd1;
    assign addr_d     = addr_q + STEP;
    // Rejects a word whose last byte would land past the end of memory.
    assign overflow   = addr_d > LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= BASE;
            word_q       <= '0;
            last_q       <= 1'b0;
            byte_idx_q   <= 2'd0;
            word_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q      <= WAIT_WORD;
                        addr_q       <= BASE;
                        word_count_q <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_hold_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        word_ready_q <= 1'b1;
                    end
                end
                WAIT_WORD: begin
                    if (word_if.word_valid) begin
                        word_ready_q <= 1'b0;
                        if (overflow) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q     <= WRITE;
                            word_q      <= word_if.word_in;
                            last_q      <= word_if.word_last;
                            byte_idx_q  <= 2'd0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr_q;
                            mem_wdata_q <= word_if.word_in[BYTE_W-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_q  <= byte_idx_d;
                        mem_addr_q  <= addr_q + {30'd0, byte_idx_d};
                        mem_wdata_q <= word_q[{byte_idx_d, 3'b000} +: BYTE_W];
                    end else begin
                        mem_we_q     <= 1'b0;
                        addr_q       <= addr_d;
                        word_count_q <= sat_inc(word_count_q);
                        if (last_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            state_q      <= WAIT_WORD;
                            word_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_if.word_ready = word_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign cpu_hold   = cpu_hold_q;
    assign word_count = word_count_q;

endmodule
